// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Index/tag widths are derived from the line count by the helper functions.
package dcache_pkg;

  localparam int WORD_W   = 32;
  localparam int WORDS    = 4;
  localparam int WSEL_W   = 2;
  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    WR_DONE = 2'd3
  } state_e;

  // Latched memory transaction: block address for fills, word address + data for stores
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } lat_req_t;

  function automatic int idx_w(input int lines);
    return (lines < 2) ? 1 : $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return 32 - OFFSET_W - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, single-cycle line fill or word write.
// Only the valid bits are reset; tags and data are qualified by valid.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int BLOCK_W   = 128,
  parameter int IDX_W     = idx_w(NUM_LINES),
  parameter int TAG_W     = tag_w(NUM_LINES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [WORDS-1:0][WORD_W-1:0]  rd_data,
  input  logic                          fill_en,
  input  logic [IDX_W-1:0]              fill_idx,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic [BLOCK_W-1:0]            fill_data,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [WSEL_W-1:0]             wr_sel,
  input  logic [WORD_W-1:0]             wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst)          valid_q <= '0;
    else if (fill_en) valid_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_q[fill_idx] <= fill_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

  // One storage column per word so a store touches only its own column
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [WORD_W-1:0] word_q [NUM_LINES];

    always_ff @(posedge clk) begin
      if (fill_en)
        word_q[fill_idx] <= fill_data[w*WORD_W +: WORD_W];
      else if (wr_en && (wr_sel == WSEL_W'(w)))
        word_q[wr_idx] <= wr_data;
    end

    assign rd_data[w] = word_q[rd_idx];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Holds the FSM, the request latch and the hit comparison; storage lives in dcache_array.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = 32,
  parameter int MEM_BLOCK_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic                   cpu_re,
  input  logic                   cpu_we,
  output logic [31:0]            cpu_rdata,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [MEM_BLOCK_W-1:0] mem_rdata,
  input  logic                   mem_ready
);

  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(NUM_LINES);

  state_e   state_q, state_d;
  lat_req_t lat_q, lat_nxt;
  logic     lat_ld;

  logic [31:0]                 rd_addr;
  logic [IDX_W-1:0]            rd_idx;
  logic [TAG_W-1:0]            addr_tag;
  logic [WSEL_W-1:0]           wsel;
  logic                        rd_valid;
  logic [TAG_W-1:0]            rd_tag;
  logic [WORDS-1:0][WORD_W-1:0] rd_data;
  logic                        hit;
  logic                        fill_en, wr_en;
  logic                        unused_bits;

  // In IDLE look up the live CPU address; while a transaction is open look up the latched one
  assign rd_addr     = (state_q == IDLE) ? cpu_addr : lat_q.addr;
  assign rd_idx      = rd_addr[OFFSET_W +: IDX_W];
  assign addr_tag    = rd_addr[31 -: TAG_W];
  assign wsel        = rd_addr[3:2];
  assign hit         = rd_valid && (rd_tag == addr_tag);
  assign unused_bits = ^rd_addr[1:0];

  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .BLOCK_W   (MEM_BLOCK_W),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_idx  (rd_idx),
    .fill_tag  (addr_tag),
    .fill_data (mem_rdata),
    .wr_en     (wr_en),
    .wr_idx    (rd_idx),
    .wr_sel    (wsel),
    .wr_data   (lat_q.wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lat_ld) lat_q <= lat_nxt;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    cpu_rdata = '0;
    fill_en   = 1'b0;
    wr_en     = 1'b0;
    lat_ld    = 1'b0;
    lat_nxt   = lat_q;

    case (state_q)
      IDLE: begin
        // A store wins when both requests are raised together
        if (cpu_we) begin
          stall   = 1'b1;
          lat_ld  = 1'b1;
          lat_nxt = '{addr: {cpu_addr[31:2], 2'b00}, wdata: cpu_wdata};
          state_d = WR_MEM;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = rd_data[wsel];
          end else begin
            stall   = 1'b1;
            lat_ld  = 1'b1;
            lat_nxt = '{addr: {cpu_addr[31:4], 4'b0000}, wdata: lat_q.wdata};
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          wr_en   = hit;
          state_d = WR_DONE;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      cpu_rdata = '0;
      fill_en   = 1'b0;
      wr_en     = 1'b0;
      lat_ld    = 1'b0;
    end
  end

endmodule
